// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, prefix FSM states and default keymap for the PS/2 keypad front end
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Byte i is the scan code of logical key i (key 0 = 0x16 ... key 15 = 0x3C)
  localparam int DEFAULT_NUM_KEYS = 16;
  localparam logic [DEFAULT_NUM_KEYS*8-1:0] DEFAULT_KEYMAP = {
    8'h3C, 8'h35, 8'h2C, 8'h2D, 8'h24, 8'h1D, 8'h15, 8'h46,
    8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16
  };

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } prefix_state_e;

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 line conditioning and 11-bit frame receiver with parity and timeout checks
module ps2_frame_rx #(
  parameter int CLK_DIV       = 249,
  parameter int FILTER_LEN    = 4,
  parameter int TIMEOUT_TICKS = 4000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_strobe,
  output logic       frame_err
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam int L_CLK = 0;
  localparam int L_DAT = 1;

  logic [1:0]       s1_q, s1_d, s2_q, s2_d;
  logic [1:0]       filt_q, filt_d;
  logic [FLT_W-1:0] fcnt_q [2];
  logic [FLT_W-1:0] fcnt_d [2];
  logic [DIV_W-1:0] div_q, div_d;
  logic [10:0]      sr_q, sr_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic             strobe_q, strobe_d;
  logic             err_q, err_d;
  logic             tick;
  logic             fall;

  // Synchroniser, tick divider and per-line glitch filter
  always_comb begin
    s1_d   = {ps2_data, ps2_clk};
    s2_d   = s1_q;
    div_d  = div_q + DIV_W'(1);
    tick   = 1'b0;
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    if (div_q == DIV_W'(CLK_DIV - 1)) begin
      div_d = '0;
      tick  = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      if (tick) begin
        if (s2_q[i] != filt_q[i]) begin
          if (fcnt_q[i] == FLT_W'(FILTER_LEN - 1)) begin
            filt_d[i] = s2_q[i];
            fcnt_d[i] = '0;
          end else begin
            fcnt_d[i] = fcnt_q[i] + FLT_W'(1);
          end
        end else begin
          fcnt_d[i] = '0;
        end
      end
    end
    fall = tick && filt_q[L_CLK] && !filt_d[L_CLK];
  end

  // Frame shift-in on filtered clock falls; frame check on bit 11; mid-frame timeout
  always_comb begin
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    to_cnt_d  = to_cnt_q;
    byte_d    = byte_q;
    strobe_d  = 1'b0;
    err_d     = 1'b0;
    if (fall) begin
      sr_d     = {filt_q[L_DAT], sr_q[10:1]};
      to_cnt_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = '0;
        if (!sr_d[0] && sr_d[10] && (^sr_d[9:1])) begin
          strobe_d = 1'b1;
          byte_d   = sr_d[8:1];
        end else begin
          err_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (tick && (bit_cnt_q != 4'd0)) begin
      if (to_cnt_q == TO_W'(TIMEOUT_TICKS - 1)) begin
        bit_cnt_d = '0;
        to_cnt_d  = '0;
        err_d     = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  // State registers; idle PS/2 lines are high, so synchronisers and filters reset to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= 2'b11;
      s2_q      <= 2'b11;
      filt_q    <= 2'b11;
      fcnt_q[0] <= '0;
      fcnt_q[1] <= '0;
      div_q     <= '0;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      byte_q    <= '0;
      strobe_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
      div_q     <= div_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      to_cnt_q  <= to_cnt_d;
      byte_q    <= byte_d;
      strobe_q  <= strobe_d;
      err_q     <= err_d;
    end
  end

  assign rx_byte     = byte_q;
  assign byte_strobe = strobe_q;
  assign frame_err   = err_q;

endmodule

// File: rtl/ps2_keypad_decoder.sv
// rtl/ps2_keypad_decoder.sv - PS/2 prefix decoding, key mapping, key-down mask, event FIFO and last-key display
module ps2_keypad_decoder
  import ps2_pkg::*;
#(
  parameter int                      CLK_DIV       = 249,
  parameter int                      FILTER_LEN    = 4,
  parameter int                      TIMEOUT_TICKS = 4000,
  parameter int                      NUM_KEYS      = 16,
  parameter logic [NUM_KEYS*8-1:0]   KEYMAP        = DEFAULT_KEYMAP,
  parameter int                      FIFO_DEPTH    = 4,
  parameter int                      HOLD_CYCLES   = 10_000_000,
  localparam int                     IDX_W         = $clog2(NUM_KEYS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [IDX_W-1:0]    evt_key,
  output logic                evt_release,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] last_key_onehot,
  output logic [7:0]          last_key_idx,
  output logic                frame_err,
  output logic                overflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  logic [7:0]          rx_byte;
  logic                byte_strobe;
  prefix_state_e       state_q, state_d;
  logic [NUM_KEYS-1:0] key_down_q, key_down_d;
  logic [NUM_KEYS-1:0] onehot_q, onehot_d;
  logic [7:0]          last_idx_q, last_idx_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                push_q, push_d;
  logic [IDX_W-1:0]    push_key_q, push_key_d;
  logic                push_rel_q, push_rel_d;
  logic [IDX_W:0]      mem_q [FIFO_DEPTH];
  logic [IDX_W:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [IDX_W:0]      head_hold_q, head_hold_d;
  logic                overflow_q, overflow_d;
  logic                hit, do_make, do_break;
  logic [IDX_W-1:0]    hit_idx;
  logic                full, pop, wr_en;
  logic [IDX_W:0]      head;

  ps2_frame_rx #(
    .CLK_DIV      (CLK_DIV),
    .FILTER_LEN   (FILTER_LEN),
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_strobe(byte_strobe),
    .frame_err  (frame_err)
  );

  // Keymap lookup; scanning downwards lets the lowest matching index win
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (KEYMAP[i*8 +: 8] == rx_byte) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Prefix FSM, key-down mask, push request and hold timer (a make beats a same-cycle expiry)
  always_comb begin
    state_d    = state_q;
    key_down_d = key_down_q;
    onehot_d   = onehot_q;
    last_idx_d = last_idx_q;
    hold_cnt_d = hold_cnt_q;
    push_d     = 1'b0;
    push_key_d = push_key_q;
    push_rel_d = push_rel_q;
    do_make    = 1'b0;
    do_break   = 1'b0;
    if (onehot_q != '0) begin
      if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
        onehot_d   = '0;
        last_idx_d = '0;
        hold_cnt_d = '0;
      end else begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
    end
    if (byte_strobe) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_byte == PS2_BREAK)    state_d = ST_BRK;
          else if (rx_byte == PS2_EXT) state_d = ST_EXT;
          else                         do_make = hit;
        end
        ST_BRK: begin
          do_break = hit;
          state_d  = ST_IDLE;
        end
        ST_EXT:  state_d = (rx_byte == PS2_BREAK) ? ST_EXT_BRK : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    if (do_make) begin
      onehot_d   = NUM_KEYS'(1) << hit_idx;
      last_idx_d = 8'(hit_idx);
      hold_cnt_d = '0;
      if (!key_down_q[hit_idx]) begin
        key_down_d[hit_idx] = 1'b1;
        push_d     = 1'b1;
        push_key_d = hit_idx;
        push_rel_d = 1'b0;
      end
    end
    if (do_break) begin
      key_down_d[hit_idx] = 1'b0;
      push_d     = 1'b1;
      push_key_d = hit_idx;
      push_rel_d = 1'b1;
    end
  end

  // Event FIFO; a pop frees the slot for a same-cycle push even when full
  always_comb begin
    head        = mem_q[rd_ptr_q[PTR_W-1:0]];
    full        = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                  (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    pop         = evt_valid && evt_ready;
    wr_en       = push_q && (!full || pop);
    overflow_d  = push_q && full && !pop;
    mem_d       = mem_q;
    if (wr_en) mem_d[wr_ptr_q[PTR_W-1:0]] = {push_key_q, push_rel_q};
    wr_ptr_d    = wr_ptr_q + (PTR_W+1)'(wr_en);
    rd_ptr_d    = rd_ptr_q + (PTR_W+1)'(pop);
    head_hold_d = evt_valid ? head : head_hold_q;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      key_down_q  <= '0;
      onehot_q    <= '0;
      last_idx_q  <= '0;
      hold_cnt_q  <= '0;
      push_q      <= 1'b0;
      push_key_q  <= '0;
      push_rel_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      head_hold_q <= '0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      key_down_q  <= key_down_d;
      onehot_q    <= onehot_d;
      last_idx_q  <= last_idx_d;
      hold_cnt_q  <= hold_cnt_d;
      push_q      <= push_d;
      push_key_q  <= push_key_d;
      push_rel_q  <= push_rel_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      head_hold_q <= head_hold_d;
      overflow_q  <= overflow_d;
      mem_q       <= mem_d;
    end
  end

  assign evt_valid                = (wr_ptr_q != rd_ptr_q);
  assign {evt_key, evt_release}   = evt_valid ? head : head_hold_q;
  assign key_down                 = key_down_q;
  assign last_key_onehot          = onehot_q;
  assign last_key_idx             = last_idx_q;
  assign overflow                 = overflow_q;

endmodule

// File: tb/tb_ps2_keypad_decoder.sv
// tb/tb_ps2_keypad_decoder.sv - directed scoreboard bench for ps2_keypad_decoder
module tb_ps2_keypad_decoder;

  localparam int CLK_DIV = 4;
  localparam int FILTER_LEN = 2;
  localparam int TIMEOUT_TICKS = 50;
  localparam int NUM_KEYS = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int HOLD_CYCLES = 6000;
  localparam int HALF = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [3:0]  evt_key;
  logic        evt_release;
  logic [15:0] key_down;
  logic [15:0] last_key_onehot;
  logic [7:0]  last_key_idx;
  logic        frame_err;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  int err_cnt = 0;
  int ovf_cnt = 0;
  int snap;
  logic [4:0] exp_q [$];

  ps2_keypad_decoder #(
    .CLK_DIV(CLK_DIV), .FILTER_LEN(FILTER_LEN), .TIMEOUT_TICKS(TIMEOUT_TICKS),
    .NUM_KEYS(NUM_KEYS), .FIFO_DEPTH(FIFO_DEPTH), .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key), .evt_release(evt_release),
    .key_down(key_down), .last_key_onehot(last_key_onehot), .last_key_idx(last_key_idx),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) err_cnt++;
    if (overflow === 1'b1) ovf_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (2 * HALF) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ flip, b, 1'b0};
    send_bits(f, 11);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0);
  endtask

  task automatic push_exp(input logic [3:0] key, input logic rel);
    exp_q.push_back({key, rel});
  endtask

  task automatic pop_expect(input string tag);
    int n;
    logic [4:0] exp;
    n = 0;
    @(negedge clk);
    while (evt_valid !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 5'bx;
    check({tag, "_valid"}, {31'd0, evt_valid}, 32'd1);
    check({tag, "_evt"}, {27'd0, evt_key, evt_release}, {27'd0, exp});
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (5) @(negedge clk);
    check("rst_valid", {31'd0, evt_valid}, 32'd0);
    check("rst_key_down", {16'd0, key_down}, 32'd0);
    check("rst_onehot", {16'd0, last_key_onehot}, 32'd0);
    check("rst_idx", {24'd0, last_key_idx}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // single make of key 1
    send_byte(8'h1E); push_exp(4'd1, 1'b0);
    pop_expect("make1");
    check("make1_down", {16'd0, key_down}, 32'h0002);
    check("make1_idx", {24'd0, last_key_idx}, 32'd1);
    check("make1_onehot", {16'd0, last_key_onehot}, 32'h0002);

    // break of key 1; display persists until the hold time runs out
    send_byte(8'hF0); send_byte(8'h1E); push_exp(4'd1, 1'b1);
    pop_expect("brk1");
    check("brk1_down", {16'd0, key_down}, 32'h0000);
    check("brk1_onehot_held", {16'd0, last_key_onehot}, 32'h0002);
    begin
      int n;
      n = 0;
      while (last_key_onehot !== 16'h0 && n < 2 * HOLD_CYCLES) begin @(negedge clk); n++; end
    end
    check("hold_onehot", {16'd0, last_key_onehot}, 32'h0);
    check("hold_idx", {24'd0, last_key_idx}, 32'h0);

    // bad parity inside a break prefix: error, no event, prefix state kept
    snap = err_cnt;
    send_byte(8'hF0);
    send_frame(8'h1E, 1'b1);
    check("par_err", err_cnt - snap, 32'd1);
    check("par_noevt", {31'd0, evt_valid}, 32'd0);
    send_byte(8'h16); push_exp(4'd0, 1'b1);
    pop_expect("par_brk0");

    // truncated frame then timeout; next frame decodes cleanly
    snap = err_cnt;
    send_bits({1'b1, ~^8'h1E, 8'h1E, 1'b0}, 6);
    repeat ((TIMEOUT_TICKS + 20) * CLK_DIV) @(posedge clk);
    check("to_err", err_cnt - snap, 32'd1);
    check("to_noevt", {31'd0, evt_valid}, 32'd0);
    send_byte(8'h16); push_exp(4'd0, 1'b0);
    pop_expect("to_make0");
    check("to_down", {16'd0, key_down}, 32'h0001);

    // overflow: five makes into a four-entry FIFO with no consumer
    snap = ovf_cnt;
    send_byte(8'h26); push_exp(4'd2, 1'b0);
    send_byte(8'h25); push_exp(4'd3, 1'b0);
    send_byte(8'h2E); push_exp(4'd4, 1'b0);
    send_byte(8'h36); push_exp(4'd5, 1'b0);
    send_byte(8'h3D);
    check("ovf_pulses", ovf_cnt - snap, 32'd1);
    check("ovf_idx", {24'd0, last_key_idx}, 32'd6);
    check("ovf_down", {16'd0, key_down}, 32'h007D);
    for (int i = 0; i < 4; i++) pop_expect("ovf_pop");
    @(negedge clk);
    check("ovf_drained", {31'd0, evt_valid}, 32'd0);

    // extended sequences are discarded; typematic repeats give one make
    send_byte(8'hF0); send_byte(8'h16); push_exp(4'd0, 1'b1);
    pop_expect("rel0");
    snap = err_cnt;
    send_byte(8'hE0); send_byte(8'h16);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h16);
    send_byte(8'hE0); send_byte(8'h75);
    check("ext_noevt", {31'd0, evt_valid}, 32'd0);
    check("ext_down", {31'd0, key_down[0]}, 32'd0);
    check("ext_noerr", err_cnt - snap, 32'd0);
    send_byte(8'h16); send_byte(8'h16); send_byte(8'h16); push_exp(4'd0, 1'b0);
    pop_expect("rep_make0");
    @(negedge clk);
    check("rep_single", {31'd0, evt_valid}, 32'd0);
    check("rep_idx", {24'd0, last_key_idx}, 32'd0);
    check("rep_onehot", {16'd0, last_key_onehot}, 32'h0001);

    // reset mid-frame discards everything, including the partial frame
    send_bits({1'b1, ~^8'h2E, 8'h2E, 1'b0}, 5);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("mrst_down", {16'd0, key_down}, 32'h0);
    check("mrst_onehot", {16'd0, last_key_onehot}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_byte(8'h1E); push_exp(4'd1, 1'b0);
    pop_expect("mrst_make1");
    check("mrst_down1", {16'd0, key_down}, 32'h0002);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
